// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler for a three-floor car
// Latches hall/car calls, sequences one-floor moves and times the door dwell.
module elevator_call_scheduler #(
  parameter int DOOR_CYCLES  = 4,
  parameter int MOVE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       floor1_up,
  input  logic       floor2_down,
  input  logic       floor2_up,
  input  logic       floor3_down,
  input  logic       floor1_button,
  input  logic       floor2_button,
  input  logic       floor3_button,
  input  logic       move_done,
  output logic       move_req,
  output logic       move_up,
  output logic       floor_1_indi,
  output logic       floor_2_indi,
  output logic       floor_3_indi,
  output logic       door_open,
  output logic       dir_up,
  output logic [6:0] pending,
  output logic       fault
);

  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam int TW = $clog2(MOVE_TIMEOUT + 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(MOVE_TIMEOUT - 1);

  // Call bit layout: {car3, car2, car1, dn3, dn2, up2, up1}
  localparam logic [6:0] M1   = 7'b0010001;
  localparam logic [6:0] M2   = 7'b0100110;
  localparam logic [6:0] M3   = 7'b1001000;
  localparam logic [6:0] UP2  = 7'b0000010;
  localparam logic [6:0] DN2  = 7'b0000100;
  localparam logic [6:0] CAR2 = 7'b0100000;

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_ARRIVE, S_DOOR, S_FAULT} state_t;

  state_t        state, state_n;
  logic [1:0]    floor, floor_n;
  logic [6:0]    pending_n, btn, p_set, s_fwd, s_rev, here_mask;
  logic          dir_n, move_up_n, above, below, flip_fwd, flip_rev;
  logic [DW-1:0] door_cnt, door_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;

  // Calls served by a stop at floor f heading in direction d; at floor 2 the
  // opposite hall call joins the set when nothing waits further along d.
  function automatic logic [6:0] serve_mask(input logic [1:0] f, input logic d,
                                            input logic beyond_up, input logic beyond_dn);
    logic [6:0] m;
    case (f)
      2'd1: m = M1;
      2'd3: m = M3;
      default: begin
        m = CAR2 | (d ? UP2 : DN2);
        if (d ? !beyond_up : !beyond_dn) m = m | (d ? DN2 : UP2);
      end
    endcase
    return m;
  endfunction

  assign btn   = {floor3_button, floor2_button, floor1_button,
                  floor3_down, floor2_down, floor2_up, floor1_up};
  assign p_set = pending | btn;

  always_comb begin
    here_mask = M3;
    above     = 1'b0;
    below     = |(pending & (M1 | M2));
    case (floor)
      2'd1: begin
        here_mask = M1;
        above     = |(pending & (M2 | M3));
        below     = 1'b0;
      end
      2'd2: begin
        here_mask = M2;
        above     = |(pending & M3);
        below     = |(pending & M1);
      end
      default: ;
    endcase
  end

  assign s_fwd    = serve_mask(floor, dir_up, above, below);
  assign s_rev    = serve_mask(floor, !dir_up, above, below);
  assign flip_fwd = |(s_fwd & p_set & (dir_up ? DN2 : UP2));
  assign flip_rev = |(s_rev & p_set & (dir_up ? UP2 : DN2));

  always_comb begin
    state_n    = state;
    floor_n    = floor;
    pending_n  = p_set;
    dir_n      = dir_up;
    move_up_n  = move_up;
    door_cnt_n = door_cnt;
    to_cnt_n   = to_cnt;
    case (state)
      S_IDLE: begin
        if (|(pending & here_mask)) begin
          state_n    = S_DOOR;
          door_cnt_n = DOOR_LOAD;
          // A call here that the current direction would not serve turns the car round.
          if (|(pending & s_fwd)) begin
            pending_n = p_set & ~s_fwd;
            dir_n     = dir_up ^ flip_fwd;
          end else begin
            pending_n = p_set & ~s_rev;
            dir_n     = !dir_up ^ flip_rev;
          end
        end else if ((dir_up && above) || (!dir_up && below) || above || below) begin
          state_n   = S_MOVE;
          to_cnt_n  = '0;
          dir_n     = (dir_up && above) || (!below && above);
          move_up_n = dir_n;
        end
      end
      S_MOVE: begin
        if (move_done) begin
          if ((floor == 2'd3 && move_up) || (floor == 2'd1 && !move_up)) begin
            state_n = S_FAULT;
          end else begin
            floor_n = move_up ? floor + 2'd1 : floor - 2'd1;
            state_n = S_ARRIVE;
          end
        end else if (to_cnt == TO_LAST) begin
          state_n = S_FAULT;
        end else begin
          to_cnt_n = to_cnt + TW'(1);
        end
      end
      S_ARRIVE: begin
        if (|(pending & s_fwd)) begin
          state_n    = S_DOOR;
          door_cnt_n = DOOR_LOAD;
          pending_n  = p_set & ~s_fwd;
          dir_n      = dir_up ^ flip_fwd;
        end else if (dir_up ? above : below) begin
          state_n   = S_MOVE;
          move_up_n = dir_up;
          to_cnt_n  = '0;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DOOR: begin
        // Presses for this stop are absorbed and hold the door for a full dwell.
        pending_n = p_set & ~s_fwd;
        dir_n     = dir_up ^ flip_fwd;
        if (|(btn & s_fwd)) begin
          door_cnt_n = DOOR_LOAD;
        end else if (door_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          door_cnt_n = door_cnt - DW'(1);
        end
      end
      S_FAULT: ;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      floor    <= 2'd1;
      pending  <= '0;
      dir_up   <= 1'b1;
      move_up  <= 1'b0;
      door_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_n;
      floor    <= floor_n;
      pending  <= pending_n;
      dir_up   <= dir_n;
      move_up  <= move_up_n;
      door_cnt <= door_cnt_n;
      to_cnt   <= to_cnt_n;
    end
  end

  assign move_req     = (state == S_MOVE);
  assign door_open    = (state == S_DOOR);
  assign fault        = (state == S_FAULT);
  assign floor_1_indi = (floor == 2'd1);
  assign floor_2_indi = (floor == 2'd2);
  assign floor_3_indi = (floor == 2'd3);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed checks for elevator_call_scheduler
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn = '0;
  logic       resp_done = 1'b0;
  logic       man_done = 1'b0;
  logic       auto_done = 1'b0;
  logic       move_done;
  logic       move_req, move_up, door_open, dir_up, fault;
  logic       floor_1_indi, floor_2_indi, floor_3_indi;
  logic [6:0] pending;

  int n_checks = 0;
  int n_pass = 0;

  int n_req = 0, n_req_up = 0, n_stop = 0, door_len = 0, last_door_len = 0;
  int onehot_bad = 0, unstable = 0;
  logic [11:0] floor_trail = '0;
  logic [11:0] stop_trail = '0;
  logic        prev_req = 1'b0, prev_door = 1'b0, prev_up = 1'b0;
  logic [1:0]  prev_code = 2'd0;
  logic [1:0]  cur_code;

  assign move_done = resp_done | man_done;
  assign cur_code  = floor_1_indi ? 2'd1 : floor_2_indi ? 2'd2 : floor_3_indi ? 2'd3 : 2'd0;

  always #5 clk = ~clk;

  elevator_call_scheduler #(.DOOR_CYCLES(4), .MOVE_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .floor1_up(btn[0]), .floor2_up(btn[1]), .floor2_down(btn[2]), .floor3_down(btn[3]),
    .floor1_button(btn[4]), .floor2_button(btn[5]), .floor3_button(btn[6]),
    .move_done(move_done), .move_req(move_req), .move_up(move_up),
    .floor_1_indi(floor_1_indi), .floor_2_indi(floor_2_indi), .floor_3_indi(floor_3_indi),
    .door_open(door_open), .dir_up(dir_up), .pending(pending), .fault(fault)
  );

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!$onehot({floor_1_indi, floor_2_indi, floor_3_indi})) onehot_bad <= onehot_bad + 1;
    if (cur_code != prev_code) floor_trail <= {floor_trail[9:0], cur_code};
    if (move_req && !prev_req) begin
      n_req <= n_req + 1;
      if (move_up) n_req_up <= n_req_up + 1;
    end
    if (move_req && prev_req && move_up != prev_up) unstable <= unstable + 1;
    if (door_open && !prev_door) begin
      n_stop     <= n_stop + 1;
      stop_trail <= {stop_trail[9:0], cur_code};
    end
    if (door_open) begin
      door_len <= door_len + 1;
    end else begin
      if (prev_door) last_door_len <= door_len;
      door_len <= 0;
    end
    prev_code <= cur_code;
    prev_req  <= move_req;
    prev_up   <= move_up;
    prev_door <= door_open;
  end

  // Motion unit model: answers each move request three cycles later
  initial begin
    forever begin
      @(posedge clk); #1;
      if (auto_done && move_req) begin
        @(posedge clk); @(posedge clk); #1;
        resp_done = 1'b1;
        @(posedge clk); #1;
        resp_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_door(input logic lvl, input string tag);
    int n;
    n = 0;
    while (door_open !== lvl && n < 300) begin
      tick();
      n++;
    end
    check(tag, door_open, lvl);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_outs"}, {move_req, move_up, door_open, fault, dir_up,
                           floor_1_indi, floor_2_indi, floor_3_indi}, 8'b0000_1100);
    check({tag, "_pending"}, pending, 7'h00);
  endtask

  initial begin
    int r0, u0, s0, n;

    repeat (3) tick();
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // Hall call at the idle floor
    btn = 7'h01;
    tick();
    check("t1_latch", pending, 7'h01);
    check("t1_door_early", door_open, 1'b0);
    tick();
    btn = 7'h00;
    check("t1_door_open", door_open, 1'b1);
    check("t1_cleared", pending, 7'h00);
    wait_door(1'b0, "t1_close");
    tick();
    check("t1_dwell", last_door_len, 4);
    check("t1_floor", floor_1_indi, 1'b1);

    // Car call to floor 3, straight through floor 2
    r0 = n_req; u0 = n_req_up; s0 = n_stop;
    auto_done = 1'b1;
    btn = 7'h40;
    tick();
    btn = 7'h00;
    check("t2_req_early", move_req, 1'b0);
    tick();
    check("t2_req", {move_req, move_up}, 2'b11);
    wait_door(1'b1, "t2_open");
    check("t2_floor3", floor_3_indi, 1'b1);
    wait_door(1'b0, "t2_close");
    tick();
    check("t2_moves", n_req - r0, 2);
    check("t2_moves_up", n_req_up - u0, 2);
    check("t2_stops", n_stop - s0, 1);
    check("t2_trail", floor_trail[5:0], 6'b01_10_11);
    check("t2_dwell", last_door_len, 4);

    // SCAN from floor 3: dn3 here, up2 and car1 below
    r0 = n_req; u0 = n_req_up; s0 = n_stop;
    btn = 7'b0011010;
    tick();
    btn = 7'h00;
    wait_door(1'b1, "t4_open3");
    check("t4_floor3", floor_3_indi, 1'b1);
    wait_door(1'b0, "t4_close3");
    wait_door(1'b1, "t4_open1");
    check("t4_floor1", {floor_1_indi, dir_up}, 2'b10);
    check("t4_pend1", pending, 7'h02);
    wait_door(1'b0, "t4_close1");
    wait_door(1'b1, "t4_open2");
    check("t4_floor2", {floor_2_indi, dir_up}, 2'b11);
    wait_door(1'b0, "t4_close2");
    tick();
    check("t4_pend_end", pending, 7'h00);
    check("t4_stops", stop_trail[5:0], 6'b11_01_10);
    check("t4_moves", n_req - r0, 3);
    check("t4_moves_up", n_req_up - u0, 1);

    // Dwell restart by a serve-set press at floor 2
    btn = 7'h02;
    tick();
    btn = 7'h00;
    tick();
    check("t6_open", door_open, 1'b1);
    tick();
    btn = 7'h02;
    tick();
    btn = 7'h00;
    check("t6_absorb", pending, 7'h00);
    repeat (3) tick();
    check("t6_hold", door_open, 1'b1);
    tick();
    check("t6_close", door_open, 1'b0);
    tick();
    check("t6_dwell", last_door_len, 6);

    // floor2_down with nothing above is absorbed and reverses the car
    btn = 7'h02;
    tick();
    btn = 7'h00;
    tick();
    check("t7b_open", {door_open, dir_up}, 2'b11);
    btn = 7'h04;
    tick();
    btn = 7'h00;
    check("t7b_absorb", {pending, dir_up}, 8'h00);
    wait_door(1'b0, "t7b_close");
    tick();
    check("t7b_dwell", last_door_len, 5);

    // floor2_down latches while a floor-3 call is waiting
    btn = 7'h02;
    tick();
    btn = 7'h00;
    tick();
    check("t7a_open", {door_open, dir_up}, 2'b11);
    btn = 7'h40;
    tick();
    btn = 7'h04;
    tick();
    btn = 7'h00;
    check("t7a_latch", pending, 7'h44);
    check("t7a_still_open", door_open, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("door_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Up-travel stop at floor 2 for up2, car3 kept
    s0 = n_stop;
    btn = 7'b1000010;
    tick();
    btn = 7'h00;
    wait_door(1'b1, "t3_open2");
    check("t3_floor2", floor_2_indi, 1'b1);
    check("t3_pend2", pending, 7'h40);
    wait_door(1'b0, "t3_close2");
    wait_door(1'b1, "t3_open3");
    check("t3_floor3", floor_3_indi, 1'b1);
    wait_door(1'b0, "t3_close3");
    tick();
    check("t3_pend_end", pending, 7'h00);
    check("t3_trail", floor_trail[5:0], 6'b01_10_11);
    check("t3_stops", {stop_trail[3:0], 4'(n_stop - s0)}, {4'b10_11, 4'd2});

    // Move timeout
    auto_done = 1'b0;
    btn = 7'h10;
    tick();
    btn = 7'h00;
    tick();
    check("flt_req", {move_req, move_up}, 2'b10);
    n = 0;
    while (move_req && !fault && n < 200) begin
      n++;
      tick();
    end
    check("flt_cycles", n, 64);
    check("flt_outs", {fault, move_req, door_open}, 3'b100);
    btn = 7'h20;
    tick();
    btn = 7'h00;
    tick();
    check("flt_latch", pending, 7'h30);
    repeat (3) tick();
    check("flt_sticky", {fault, move_req}, 2'b10);
    #2 rst_n = 1'b0;
    #1 check_reset("flt_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Stray move_done outside MOVE
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    check("stray_done", {floor_1_indi, floor_2_indi, floor_3_indi, fault, move_req}, 5'b10000);

    check("onehot", onehot_bad, 0);
    check("move_up_stable", unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Call-scheduling front end for the three-floor car.
- Latches hall and car calls and runs a SCAN (collective) policy to choose travel direction.
- Sequences a one-floor-per-transaction motion unit through a req/done handshake.
- Times door dwell, drives the floor indicators and door, and flags a stuck car.

Parameters:
- DOOR_CYCLES, 4: clock cycles door_open stays high per stop (>=1).
- MOVE_TIMEOUT, 64: max cycles move_req may wait for move_done before fault.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- floor1_up  input  1  hall call, floor 1 up (level, sampled each clk).
- floor2_down  input  1  hall call, floor 2 down.
- floor2_up  input  1  hall call, floor 2 up.
- floor3_down  input  1  hall call, floor 3 down.
- floor1_button  input  1  car call, floor 1.
- floor2_button  input  1  car call, floor 2.
- floor3_button  input  1  car call, floor 3.
- move_done  input  1  one-cycle pulse: motion unit completed the requested one-floor move.
- move_req  output  1  request one-floor move; held until move_done.
- move_up  output  1  direction of move_req (1 up, 0 down); stable while move_req is high.
- floor_1_indi  output  1  car at floor 1 (one-hot with the next two).
- floor_2_indi  output  1  car at floor 2.
- floor_3_indi  output  1  car at floor 3.
- door_open  output  1  door open.
- dir_up  output  1  current SCAN direction.
- pending  output  7  latched calls {car3,car2,car1,dn3,dn2,up2,up1}.
- fault  output  1  sticky move timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, floor=1, pending=0, dir_up=1.
  - move_req=0, move_up=0, door_open=0, fault=0.
  - floor_1_indi=1, floor_2_indi=0, floor_3_indi=0.
  - The motion unit shares rst_n, so reset mid-move is defined as return to floor 1 state.
- Call latch:
  - A button high at a posedge sets its pending bit, visible the next cycle.
  - Set has priority over clear in the same cycle, except for calls at the current floor while in DOOR (see DOOR).
- "Above"/"below": any pending call (hall or car) at a floor strictly above/below the current floor.
- "Serve set at floor f, direction d":
  - car[f];
  - the hall call at f matching d;
  - the opposite hall call at f, if nothing is pending beyond f in direction d (this reverses dir_up).
  - At floor 1 the set includes up1; at floor 3 it includes dn3.
- IDLE:
  - Evaluated every cycle, in priority order.
  - Any pending call at the current floor -> DOOR.
  - Else, if dir_up and above: move up.
  - Else, if !dir_up and below: move down.
  - Else, if above: dir_up<=1, move up.
  - Else, if below: dir_up<=0, move down.
  - Else remain IDLE.
  - "Move" = enter MOVE with move_req=1 and move_up=dir_up in the same cycle as the transition.
- MOVE:
  - move_req is held high and the timeout counter counts.
  - On move_done: floor += / -= 1, move_req=0, go to ARRIVE.
  - move_done while not in MOVE is ignored.
  - move_done at floor 3 with move_up=1, or floor 1 with move_up=0, is an error: set fault, go to FAULT.
- ARRIVE (1 cycle):
  - Stop if the serve set at the new floor in dir_up is non-empty -> DOOR.
  - Otherwise re-issue the move (MOVE) in the same direction.
- DOOR:
  - door_open=1 for DOOR_CYCLES cycles.
  - On entry, clear the serve set; the reversal rule updates dir_up.
  - A serve-set button at the current floor pressed during DOOR is not latched and restarts the dwell counter.
  - Other calls latch normally.
  - On expiry: door_open=0 -> IDLE.
- FAULT:
  - Entered when MOVE lasts MOVE_TIMEOUT cycles without move_done.
  - move_req=0, door_open=0, fault=1.
  - Calls keep latching; exit only by reset.
- Indicators always reflect the registered floor: one-hot, never zero, never two high.
- Latency:
  - Hall call at the idle floor -> door_open high 2 cycles after the press edge (latch + IDLE decision).
  - Remote call -> move_req high 2 cycles after the press edge.

Test Plan:
- After reset, floor1_up pulsed 2 cycles:
  - pending[0]=1 one cycle later;
  - door_open high 4 cycles;
  - pending returns to 0; floor_1_indi=1 throughout.
- Idle at floor 1, floor3_button pulsed, bench answers each move_req with move_done after 3 cycles:
  - two move_req/move_up=1 transactions;
  - floor_2_indi then floor_3_indi;
  - no stop at floor 2; door_open 4 cycles at floor 3.
- Car moving 1->2->3 with floor2_up and floor3_button pending:
  - stops at floor 2 (up2 cleared, car3 kept), then floor 3;
  - two door openings.
- At floor 3 after floor3_down, floor2_up, floor1_button latched:
  - descends with dir_up=0 and stops at floor 1 first;
  - floor 2 is passed because up2 is opposite and calls remain beyond;
  - then reverses to floor 2 (dir_up=1).
- move_req raised, move_done withheld for 64 cycles:
  - fault=1, move_req=0;
  - new presses still set pending;
  - rst_n low mid-fault returns all outputs to reset values asynchronously.
- During DOOR at floor 2 (dir_up=1), pressing floor2_up restarts the dwell, so door_open stays high 4 cycles past the press.
- During the same DOOR, pressing floor2_down:
  - latches dn2 if floor 3 calls are pending;
  - otherwise is cleared/absorbed by the reversal rule.
